// File: rtl/pwm_led_bank_pkg.sv
// Shared constants and store-lane helpers for the PWM LED bank.
package pwm_pkg;

  typedef logic [31:0] word_t;

  // Register offsets from the window base
  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_PRESCALE = 8'h04;
  localparam logic [7:0] OFF_PERIOD   = 8'h08;
  localparam logic [7:0] OFF_DUTY0    = 8'h0C;

  // CTRL bit positions
  localparam int CTRL_EN     = 0;
  localparam int CTRL_INVERT = 1;

  // Store size codes carried on funct3
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // Byte lanes touched by a store; misaligned or unknown sizes touch nothing.
  function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] lane);
    case (funct3)
      F3_SB:   return 4'b0001 << lane;
      F3_SH:   return lane[0] ? 4'b0000 : (4'b0011 << lane);
      F3_SW:   return (lane == 2'd0) ? 4'b1111 : 4'b0000;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicate the LSB-aligned store data across all lanes so the mask alone picks the target.
  function automatic word_t lane_data(input logic [2:0] funct3, input word_t data);
    case (funct3)
      F3_SB:   return {4{data[7:0]}};
      F3_SH:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  // Merge new bytes into an old word under a byte-lane mask.
  function automatic word_t merge_lanes(input word_t old_word, input word_t new_word,
                                        input logic [3:0] mask);
    word_t bits;
    for (int b = 0; b < 4; b++) bits[8*b +: 8] = {8{mask[b]}};
    return (old_word & ~bits) | (new_word & bits);
  endfunction

endpackage

// File: rtl/pwm_led_bank_if.sv
// Load/store port shared with memory: store strobe and data in, registered readback out.
interface pwm_led_bank_if;
  import pwm_pkg::*;

  logic       write_mem;
  logic [2:0] funct3;
  word_t      write_address;
  word_t      write_data;
  word_t      read_address;
  word_t      read_data;
  logic       read_hit;

  modport master (
    output write_mem, funct3, write_address, write_data, read_address,
    input  read_data, read_hit
  );

  modport slave (
    input  write_mem, funct3, write_address, write_data, read_address,
    output read_data, read_hit
  );
endinterface

// File: rtl/pwm_led_bank_channel.sv
// One PWM channel: duty shadow loaded at period wrap, comparator and output flop.
module pwm_channel #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] duty,
  input  logic [CNT_WIDTH-1:0] cnt,
  input  logic                 en,
  input  logic                 invert,
  output logic                 pwm
);
  logic [CNT_WIDTH-1:0] duty_sh;

  // Shadow the duty on load; output is high while the counter is below the shadowed duty.
  always_ff @(posedge clk) begin
    if (reset) begin
      duty_sh <= '0;
      pwm     <= 1'b0;
    end else begin
      if (load) duty_sh <= duty;
      pwm <= invert ^ (en & (cnt < duty_sh));
    end
  end
endmodule

// File: rtl/pwm_led_bank.sv
// Memory-mapped N-channel PWM bank; ch0 drives the LED, ch1..3 the RGB R/G/B outputs.
module pwm_led_bank
  import pwm_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned PRE_WIDTH = 16,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
) (
  input  logic              clk,
  input  logic              reset,
  pwm_led_bank_if.slave     bus,
  output logic [NUM_CH-1:0] pwm_out
);
  localparam word_t WIN_BYTES = word_t'(32'(OFF_DUTY0) + 4 * NUM_CH);

  logic [1:0]           ctrl, ctrl_nxt;
  logic [PRE_WIDTH-1:0] prescale, prescale_nxt, pre_cnt;
  logic [CNT_WIDTH-1:0] period, period_nxt, period_sh, cnt;
  logic [CNT_WIDTH-1:0] duty     [NUM_CH];
  logic [CNT_WIDTH-1:0] duty_nxt [NUM_CH];
  word_t                wr_off, rd_off, wdata, rd_word;
  logic [7:0]           wr_reg, rd_reg;
  logic [3:0]           wmask;
  logic                 wr_hit, rd_hit, en, tick, wrap, load_sh;

  // Window decode for both ports and store-lane preparation.
  always_comb begin
    wr_off = bus.write_address - BASE_ADDR;
    rd_off = bus.read_address - BASE_ADDR;
    wr_hit = bus.write_mem && (wr_off < WIN_BYTES);
    rd_hit = rd_off < WIN_BYTES;
    wr_reg = wr_off[7:0] & 8'hFC;
    rd_reg = rd_off[7:0] & 8'hFC;
    wmask  = lane_mask(bus.funct3, bus.write_address[1:0]);
    wdata  = lane_data(bus.funct3, bus.write_data);
  end

  // Next value of every live register after this cycle's store; bits above each width are dropped.
  // NOTE: each output is given its hold value first, so no decode path can infer a latch.
  always_comb begin
    ctrl_nxt     = ctrl;
    prescale_nxt = prescale;
    period_nxt   = period;
    for (int i = 0; i < NUM_CH; i++) duty_nxt[i] = duty[i];
    if (wr_hit) begin
      if (wr_reg == OFF_CTRL)
        ctrl_nxt = 2'(merge_lanes(word_t'(ctrl), wdata, wmask));
      if (wr_reg == OFF_PRESCALE)
        prescale_nxt = PRE_WIDTH'(merge_lanes(word_t'(prescale), wdata, wmask));
      if (wr_reg == OFF_PERIOD)
        period_nxt = CNT_WIDTH'(merge_lanes(word_t'(period), wdata, wmask));
      for (int i = 0; i < NUM_CH; i++)
        if (wr_reg == OFF_DUTY0 + 8'(4 * i))
          duty_nxt[i] = CNT_WIDTH'(merge_lanes(word_t'(duty[i]), wdata, wmask));
    end
  end

  // Readback mux over the live (pre-store) register values.
  always_comb begin
    rd_word = '0;
    if (rd_reg == OFF_CTRL)     rd_word[1:0]           = ctrl;
    if (rd_reg == OFF_PRESCALE) rd_word[PRE_WIDTH-1:0] = prescale;
    if (rd_reg == OFF_PERIOD)   rd_word[CNT_WIDTH-1:0] = period;
    for (int i = 0; i < NUM_CH; i++)
      if (rd_reg == OFF_DUTY0 + 8'(4 * i)) rd_word[CNT_WIDTH-1:0] = duty[i];
  end

  // Live registers accept stores immediately; the counter and channels see them via shadows.
  // NOTE: the duty bank is a handful of flops rather than a RAM, so it is reset like any register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl     <= '0;
      prescale <= '0;
      period   <= '0;
      for (int i = 0; i < NUM_CH; i++) duty[i] <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples values from before the edge.
      ctrl     <= ctrl_nxt;
      prescale <= prescale_nxt;
      period   <= period_nxt;
      for (int i = 0; i < NUM_CH; i++) duty[i] <= duty_nxt[i];
    end
  end

  // Registered readback; a load outside the window returns zero with no hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.read_data <= '0;
      bus.read_hit  <= 1'b0;
    end else begin
      bus.read_data <= rd_hit ? rd_word : '0;
      bus.read_hit  <= rd_hit;
    end
  end

  // A PRESCALE lowered below the running count still ticks instead of waiting for rollover.
  assign en      = ctrl[CTRL_EN];
  assign tick    = en && (pre_cnt >= prescale);
  assign wrap    = tick && (cnt == period_sh);
  assign load_sh = wrap || (ctrl_nxt[CTRL_EN] && !en);

  // Prescaler and shared period counter; both held at zero while disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt   <= '0;
      cnt       <= '0;
      period_sh <= '0;
    end else begin
      if (!en) begin
        pre_cnt <= '0;
        cnt     <= '0;
      end else begin
        pre_cnt <= tick ? '0 : pre_cnt + PRE_WIDTH'(1);
        if (tick) cnt <= wrap ? '0 : cnt + CNT_WIDTH'(1);
      end
      if (load_sh) period_sh <= period_nxt;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
      .clk    (clk),
      .reset  (reset),
      .load   (load_sh),
      .duty   (duty_nxt[g]),
      .cnt    (cnt),
      .en     (en),
      .invert (ctrl[CTRL_INVERT]),
      .pwm    (pwm_out[g])
    );
  end
endmodule

// File: tb/tb_pwm_led_bank.sv
// Self-checking bench for pwm_led_bank: byte-level register model plus directed literal checks.
module tb_pwm_led_bank;
  import pwm_pkg::*;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;
  localparam logic [31:0] WIN  = 32'd28;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] pwm_out;
  int         total = 0;
  int         bad   = 0;

  pwm_led_bank_if bus ();

  pwm_led_bank #(
    .NUM_CH(4), .CNT_WIDTH(16), .PRE_WIDTH(16), .BASE_ADDR(BASE)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .pwm_out (pwm_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Registers held as a flat byte image of the window; stores write bytes, reads assemble words.
  logic [7:0]  m_bytes [28];
  int          m_cnt, m_pcnt, m_psh;
  int          m_dsh [4];
  logic [3:0]  exp_pwm;
  logic [31:0] exp_rd;
  logic        exp_hit;
  bit          m_valid = 1'b0;

  function automatic logic [31:0] reg_word(input int w);
    return {m_bytes[4*w+3], m_bytes[4*w+2], m_bytes[4*w+1], m_bytes[4*w]};
  endfunction

  always @(posedge clk) begin
    logic [31:0] roff, woff;
    logic        old_en, old_inv, wrap;
    if (reset) begin
      foreach (m_bytes[k]) m_bytes[k] = 8'h00;
      foreach (m_dsh[k]) m_dsh[k] = 0;
      m_cnt = 0; m_pcnt = 0; m_psh = 0;
      exp_pwm = '0; exp_rd = '0; exp_hit = 1'b0;
    end else begin
      old_en  = m_bytes[0][0];
      old_inv = m_bytes[0][1];
      roff    = bus.read_address - BASE;
      exp_hit = roff < WIN;
      exp_rd  = exp_hit ? reg_word(int'(roff >> 2)) : 32'd0;
      for (int i = 0; i < 4; i++) exp_pwm[i] = old_inv ^ (old_en && (m_cnt < m_dsh[i]));
      wrap = 1'b0;
      if (!old_en) begin
        m_cnt = 0; m_pcnt = 0;
      end else if (m_pcnt >= int'(reg_word(1))) begin
        m_pcnt = 0;
        if (m_cnt == m_psh) begin wrap = 1'b1; m_cnt = 0; end
        else m_cnt = m_cnt + 1;
      end else begin
        m_pcnt = m_pcnt + 1;
      end
      if (bus.write_mem) begin
        woff = bus.write_address - BASE;
        if (woff < WIN) begin
          case (bus.funct3)
            3'b000: m_bytes[woff] = bus.write_data[7:0];
            3'b001: if (woff[0] == 1'b0) begin
                      m_bytes[woff]   = bus.write_data[7:0];
                      m_bytes[woff+1] = bus.write_data[15:8];
                    end
            3'b010: if (woff[1:0] == 2'b00)
                      for (int b = 0; b < 4; b++) m_bytes[woff+b] = bus.write_data[8*b +: 8];
            default: ;
          endcase
          m_bytes[0] = m_bytes[0] & 8'h03;
          m_bytes[1] = 8'h00; m_bytes[2] = 8'h00; m_bytes[3] = 8'h00;
          for (int w = 1; w < 7; w++) begin
            m_bytes[4*w+2] = 8'h00;
            m_bytes[4*w+3] = 8'h00;
          end
        end
      end
      if (wrap || (m_bytes[0][0] && !old_en)) begin
        m_psh = int'(reg_word(2));
        for (int i = 0; i < 4; i++) m_dsh[i] = int'(reg_word(3 + i));
      end
    end
    m_valid = 1'b1;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("pwm_out", 32'(pwm_out), 32'(exp_pwm));
      check("read_data", bus.read_data, exp_rd);
      check("read_hit", 32'(bus.read_hit), 32'(exp_hit));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    bus.write_mem     = 1'b1;
    bus.write_address = a;
    bus.write_data    = d;
    bus.funct3        = f3;
    step();
    bus.write_mem     = 1'b0;
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] d, output logic h);
    bus.read_address = a;
    step();
    d = bus.read_data;
    h = bus.read_hit;
  endtask

  task automatic wait_rise(input int ch);
    logic prev;
    bit   ok;
    ok   = 1'b0;
    prev = pwm_out[ch];
    for (int n = 0; n < 200; n++) begin
      step();
      if (!prev && pwm_out[ch]) begin ok = 1'b1; break; end
      prev = pwm_out[ch];
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL rise_timeout: ch%0d saw no rising edge in 200 cycles, required one", ch);
    end
  endtask

  // Count cycles and high samples until the next rising edge of a channel.
  task automatic measure_period(input int ch, input int per0, input int highs0, input logic prev0,
                                output int per, output int highs);
    logic prev;
    per = per0; highs = highs0; prev = prev0;
    for (int n = 0; n < 200; n++) begin
      step();
      per++;
      if (!prev && pwm_out[ch]) break;
      highs += int'(pwm_out[ch]);
      prev = pwm_out[ch];
    end
  endtask

  task automatic count_high(input int ch, input int n, output int highs);
    highs = 0;
    for (int k = 0; k < n; k++) begin
      step();
      highs += int'(pwm_out[ch]);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          per, highs;
    logic [31:0] rd, a, d;
    logic        hit;
    logic [2:0]  f3;

    reset             = 1'b1;
    bus.write_mem     = 1'b0;
    bus.funct3        = F3_SW;
    bus.write_address = 32'd0;
    bus.write_data    = 32'd0;
    bus.read_address  = 32'd0;
    repeat (3) step();
    check("reset_pwm", 32'(pwm_out), 32'h0);
    check("reset_rd", bus.read_data, 32'h0);
    check("reset_hit", 32'(bus.read_hit), 32'h0);
    reset = 1'b0;
    step();

    // 10-cycle period, 3 high
    store(BASE + 32'h04, 32'd0, F3_SW);
    store(BASE + 32'h08, 32'd9, F3_SW);
    store(BASE + 32'h0C, 32'd3, F3_SW);
    store(BASE + 32'h00, 32'd1, F3_SW);
    wait_rise(0);
    measure_period(0, 0, 1, 1'b1, per, highs);
    check("t1_period", 32'(per), 32'd10);
    check("t1_high", 32'(highs), 32'd3);

    // prescale 3, period 4, duty 2: 20-cycle period, 8 high
    store(BASE + 32'h04, 32'd3, F3_SW);
    store(BASE + 32'h10, 32'd2, F3_SW);
    store(BASE + 32'h08, 32'd4, F3_SW);
    repeat (50) step();
    wait_rise(1);
    measure_period(1, 0, 1, 1'b1, per, highs);
    check("t2_period", 32'(per), 32'd20);
    check("t2_high", 32'(highs), 32'd8);

    // mid-period duty change only takes effect after the wrap
    store(BASE + 32'h04, 32'd0, F3_SW);
    store(BASE + 32'h08, 32'd9, F3_SW);
    store(BASE + 32'h0C, 32'd5, F3_SW);
    repeat (40) step();
    wait_rise(0);
    store(BASE + 32'h0C, 32'd8, F3_SW);
    measure_period(0, 1, 1 + int'(pwm_out[0]), pwm_out[0], per, highs);
    check("t3_cur_period", 32'(per), 32'd10);
    check("t3_cur_high", 32'(highs), 32'd5);
    measure_period(0, 0, 1, 1'b1, per, highs);
    check("t3_next_period", 32'(per), 32'd10);
    check("t3_next_high", 32'(highs), 32'd8);

    // duty 0 stays low, duty above period stays high
    store(BASE + 32'h14, 32'd0, F3_SW);
    repeat (25) step();
    count_high(2, 20, highs);
    check("t4_duty0_high", 32'(highs), 32'd0);
    store(BASE + 32'h14, 32'd10, F3_SW);
    repeat (25) step();
    count_high(2, 20, highs);
    check("t4_dutybig_high", 32'(highs), 32'd20);
    store(BASE + 32'h00, 32'd3, F3_SW);
    check("t4_inv_ch2_before", 32'(pwm_out[2]), 32'd1);
    check("t4_inv_ch3_before", 32'(pwm_out[3]), 32'd0);
    step();
    check("t4_inv_ch2_after", 32'(pwm_out[2]), 32'd0);
    check("t4_inv_ch3_after", 32'(pwm_out[3]), 32'd1);
    store(BASE + 32'h00, 32'd1, F3_SW);

    // sub-word stores
    store(BASE + 32'h0C, 32'h0000_0012, F3_SW);
    store(BASE + 32'h0D, 32'h0000_00AB, F3_SB);
    read_reg(BASE + 32'h0C, rd, hit);
    check("t5_sb", rd, 32'h0000_AB12);
    store(BASE + 32'h0D, 32'h0000_5555, F3_SH);
    read_reg(BASE + 32'h0C, rd, hit);
    check("t5_sh_misaligned", rd, 32'h0000_AB12);
    store(BASE + 32'h0C, 32'h0000_6666, 3'b011);
    read_reg(BASE + 32'h0C, rd, hit);
    check("t5_bad_funct3", rd, 32'h0000_AB12);
    store(BASE + 32'h0E, 32'h0000_7777, F3_SH);
    read_reg(BASE + 32'h0C, rd, hit);
    check("t5_upper_half_dropped", rd, 32'h0000_AB12);

    // readback window
    read_reg(BASE + 32'h08, rd, hit);
    check("t6_period_rd", rd, 32'd9);
    check("t6_period_hit", 32'(hit), 32'd1);
    read_reg(BASE - 32'd4, rd, hit);
    check("t6_below_rd", rd, 32'd0);
    check("t6_below_hit", 32'(hit), 32'd0);
    read_reg(BASE + 32'h1C, rd, hit);
    check("t6_above_rd", rd, 32'd0);
    check("t6_above_hit", 32'(hit), 32'd0);

    // reset while running
    bus.read_address = BASE + 32'h08;
    step();
    reset = 1'b1;
    step();
    check("t7_pwm", 32'(pwm_out), 32'h0);
    check("t7_rd", bus.read_data, 32'h0);
    check("t7_hit", 32'(bus.read_hit), 32'h0);
    reset = 1'b0;

    // randomized traffic checked by the model
    for (int c = 0; c < 3000; c++) begin
      bus.read_address = BASE - 32'd4 + $urandom_range(0, 40);
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        a = BASE + $urandom_range(0, 31);
        if ($urandom_range(0, 9) == 0) a = BASE - 32'd4 + $urandom_range(0, 3);
        f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        if (a - BASE < 32'd4) begin
          d    = $urandom;
          d[0] = ($urandom_range(0, 5) != 0);
        end else begin
          d = ($urandom_range(0, 4) == 0) ? $urandom : $urandom_range(0, 12);
        end
        store(a, d, f3);
      end else begin
        step();
      end
    end
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
